// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction-fetch stage that sits right after the PC register. Every cycle it
//   can issue the current PC to a 1-cycle-latency synchronous instruction memory.
//   The returned word and its PC are then captured in a small FIFO. Decode drains
//   the FIFO through a valid/ready handshake.
//
//   Slots are reserved at issue time: in-flight requests count against the free
//   space. This means a returning word always has room. When no slot can be
//   reserved, pc_stall_o asks the next-PC mux to hold the PC. flush_i drops
//   everything, both buffered and in-flight. It also keeps the fetch quiet for
//   that cycle so that the PC register can load the redirect target.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   PC_i            current PC
//   imem_addr_o     memory address (PC_i, combinational)
//   imem_req_o      memory read request this cycle
//   imem_rdata_i    memory read data, returned the cycle after the request
//   pc_stall_o      hold the PC (no fetch issued this cycle)
//   flush_i         redirect: discard buffered and in-flight entries
//   valid_o/ready_i handshake toward decode
//   instr_o, pc_o   head instruction and its PC
//   pc_plus4_o      pc_o + 4, wrapping
//   misalign_o      head PC[1:0] != 0
module fetch_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PC_i,
   output logic [WIDTH-1:0] imem_addr_o,
   output logic             imem_req_o,
   input  logic [WIDTH-1:0] imem_rdata_i,
   output logic             pc_stall_o,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] instr_o,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_plus4_o,
   output logic             misalign_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic [WIDTH-1:0] pc_mem    [DEPTH];
   logic             mis_mem   [DEPTH];

   logic [PW-1:0]    head_ptr;
   logic [PW-1:0]    tail_ptr;
   logic [CW-1:0]    count;
   logic             inflight;
   logic [WIDTH-1:0] inflight_pc;

   logic             deq;
   logic             push;
   logic             issue;
   logic [CW:0]      occupancy;

   // Requests in flight are counted as occupied slots. Because of this, a capture
   // can never find the FIFO full.
   always_comb begin
      occupancy = {1'b0, count} + (CW+1)'(inflight);
      valid_o   = (count != '0) & ~flush_i;
      deq       = valid_o & ready_i;
      push      = inflight & ~flush_i;
      issue     = ~rst & ~flush_i & ((occupancy < (CW+1)'(DEPTH)) | deq);
   end

   assign imem_addr_o = PC_i;
   assign imem_req_o  = issue;
   assign pc_stall_o  = ~rst & ~flush_i & ~issue;

   assign instr_o    = instr_mem[head_ptr];
   assign pc_o       = pc_mem[head_ptr];
   assign misalign_o = mis_mem[head_ptr];
   assign pc_plus4_o = pc_o + WIDTH'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr    <= '0;
         tail_ptr    <= '0;
         count       <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
            mis_mem[i]   <= 1'b0;
         end
      end else if (flush_i) begin
         // A response due next cycle belongs to the wrong path. Clearing
         // inflight here makes sure it is never captured.
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue)
            inflight_pc <= PC_i;
         if (push) begin
            instr_mem[tail_ptr] <= imem_rdata_i;
            pc_mem[tail_ptr]    <= inflight_pc;
            mis_mem[tail_ptr]   <= (inflight_pc[1:0] != 2'b00);
            tail_ptr            <= tail_ptr + PW'(1);
         end
         if (deq)
            head_ptr <= head_ptr + PW'(1);
         count <= count + CW'(push) - CW'(deq);
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) deq |-> (count != '0));

endmodule
